// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: run control, ROM fetch port, branch/LUT programming and status.
// The master side (top level or bench) drives the controls; the sequencer is the slave.
interface fetch_sequencer_if #(
  parameter int A  = 10,
  parameter int W  = 9,
  parameter int CW = 16
);
  logic          Start;
  logic          Stall;
  logic [W-1:0]  InstIn;
  logic          BranchEn;
  logic [2:0]    BranchIdx;
  logic          LutWe;
  logic [2:0]    LutWaddr;
  logic [A-1:0]  LutWdata;
  logic [A-1:0]  InstAddress;
  logic          InstValid;
  logic          Done;
  logic [CW-1:0] CycleCount;

  modport master (
    output Start, Stall, InstIn, BranchEn, BranchIdx, LutWe, LutWaddr, LutWdata,
    input  InstAddress, InstValid, Done, CycleCount
  );

  modport slave (
    input  Start, Stall, InstIn, BranchEn, BranchIdx, LutWe, LutWaddr, LutWdata,
    output InstAddress, InstValid, Done, CycleCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: sequential stepping, LUT-expanded branches,
// halt-word detection and a saturating run-cycle counter.
//
// state  | meaning
// S_IDLE | PC parked at 0, waiting for Start
// S_RUN  | fetching; PC steps, branches or holds on Stall
// S_HALT | halt word seen; PC and counter frozen, Done high
module fetch_sequencer #(
  parameter int A  = 10,
  parameter int W  = 9,
  parameter int CW = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [A-1:0]  lut_q [8];
  logic [A-1:0]  lut_d [8];

  logic          halt_word;
  logic [CW-1:0] cnt_inc;

  assign halt_word = (bus.InstIn == {W{1'b1}});
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + {{(CW-1){1'b0}}, 1'b1};

  // Branches read lut_q, so a same-cycle write to the selected index is not yet visible.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lut_d[i] = lut_q[i];
    end
    if (bus.LutWe) begin
      lut_d[bus.LutWaddr] = bus.LutWdata;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (bus.Start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (!bus.Stall) begin
          if (halt_word) begin
            state_d = S_HALT;
          end else if (bus.BranchEn) begin
            pc_d = lut_q[bus.BranchIdx];
          end else begin
            pc_d = pc_q + {{(A-1){1'b0}}, 1'b1};
          end
        end
      end
      S_HALT: begin
        if (bus.Start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        lut_q[i] <= lut_d[i];
      end
    end
  end

  assign bus.InstAddress = pc_q;
  assign bus.InstValid   = (state_q == S_RUN) && !bus.Stall;
  assign bus.Done        = done_q;
  assign bus.CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: per-scenario stimulus vectors, expected
// outputs queued as each cycle is driven and compared at the following negedge.
module tb_fetch_sequencer;
  localparam int A  = 10;
  localparam int W  = 9;
  localparam int CW = 16;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  fetch_sequencer_if #(.A(A), .W(W), .CW(CW)) bus ();
  fetch_sequencer #(.A(A), .W(W), .CW(CW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  logic [W-1:0] rom [0:(1<<A)-1];
  assign bus.InstIn = rom[bus.InstAddress];

  typedef struct packed {
    logic rst, start, stall, br;
    logic [2:0] idx;
    logic we;
    logic [2:0] wa;
    logic [A-1:0] wd;
    logic [A-1:0] pc;
    logic v, d;
    logic [CW-1:0] cnt;
  } vec_t;

  typedef struct packed {
    logic [A-1:0] pc;
    logic v, d;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic rst, input logic start, input logic stall,
                              input logic br, input int idx, input logic we, input int wa,
                              input int wd, input int pc, input logic v, input logic d,
                              input int cnt);
    vec_t m;
    m.rst = rst; m.start = start; m.stall = stall; m.br = br;
    m.idx = 3'(idx); m.we = we; m.wa = 3'(wa); m.wd = A'(wd);
    m.pc = A'(pc); m.v = v; m.d = d; m.cnt = CW'(cnt);
    return m;
  endfunction

  task automatic drive(input vec_t x);
    Reset         = x.rst;
    bus.Start     = x.start;
    bus.Stall     = x.stall;
    bus.BranchEn  = x.br;
    bus.BranchIdx = x.idx;
    bus.LutWe     = x.we;
    bus.LutWaddr  = x.wa;
    bus.LutWdata  = x.wd;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << A); i++) rom[i] = '0;
  endtask

  task automatic test_reset();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clk); @(posedge Clk); #1;
    checks++;
    if (bus.InstAddress !== '0) begin
      errors++; $display("FAIL reset_addr got %h want 000", bus.InstAddress);
    end
    checks++;
    if (bus.InstValid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.InstValid);
    end
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", bus.Done);
    end
    checks++;
    if (bus.CycleCount !== '0) begin
      errors++; $display("FAIL reset_count got %0d want 0", bus.CycleCount);
    end
  endtask

  task automatic test_basic();
    vec_t vs[$];
    exp_t e, o;
    clear_rom();
    rom[0] = 9'h001; rom[1] = 9'h001; rom[2] = 9'h1FF;
    vs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 2));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 3));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 3));
    foreach (vs[k]) begin
      drive(vs[k]);
      sb.push_back(exp_t'({vs[k].pc, vs[k].v, vs[k].d, vs[k].cnt}));
      @(negedge Clk);
      e = sb.pop_front();
      o = exp_t'({bus.InstAddress, bus.InstValid, bus.Done, bus.CycleCount});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic cyc %0d got pc=%h v=%b d=%b cnt=%0d want pc=%h v=%b d=%b cnt=%0d",
                 k, o.pc, o.v, o.d, o.cnt, e.pc, e.v, e.d, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch();
    vec_t vs[$];
    exp_t e, o;
    clear_rom();
    rom[10'h042] = 9'h1FF;
    vs.push_back(mk(0, 1, 0, 0, 0, 1, 5, 'h040, 2, 0, 1, 3));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 2));
    vs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 3, 1, 0, 3));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h040, 1, 0, 4));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h041, 1, 0, 5));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h042, 1, 0, 6));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h042, 0, 1, 7));
    foreach (vs[k]) begin
      drive(vs[k]);
      sb.push_back(exp_t'({vs[k].pc, vs[k].v, vs[k].d, vs[k].cnt}));
      @(negedge Clk);
      e = sb.pop_front();
      o = exp_t'({bus.InstAddress, bus.InstValid, bus.Done, bus.CycleCount});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch cyc %0d got pc=%h v=%b d=%b cnt=%0d want pc=%h v=%b d=%b cnt=%0d",
                 k, o.pc, o.v, o.d, o.cnt, e.pc, e.v, e.d, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_stall();
    vec_t vs[$];
    exp_t e, o;
    clear_rom();
    rom[4] = 9'h1FF;
    vs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 'h042, 0, 1, 7));
    for (int i = 0; i < 4; i++) vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, i, 1, 0, i));
    vs.push_back(mk(0, 0, 1, 1, 5, 0, 0, 0, 4, 0, 0, 4));
    vs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 4, 0, 0, 5));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 6));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1, 7));
    foreach (vs[k]) begin
      drive(vs[k]);
      sb.push_back(exp_t'({vs[k].pc, vs[k].v, vs[k].d, vs[k].cnt}));
      @(negedge Clk);
      e = sb.pop_front();
      o = exp_t'({bus.InstAddress, bus.InstValid, bus.Done, bus.CycleCount});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall cyc %0d got pc=%h v=%b d=%b cnt=%0d want pc=%h v=%b d=%b cnt=%0d",
                 k, o.pc, o.v, o.d, o.cnt, e.pc, e.v, e.d, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_wrap();
    vec_t vs[$];
    exp_t e, o;
    clear_rom();
    rom[1] = 9'h1FF;
    vs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 'h3FF, 4, 0, 1, 7));
    vs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h3FF, 1, 0, 1));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4));
    foreach (vs[k]) begin
      drive(vs[k]);
      sb.push_back(exp_t'({vs[k].pc, vs[k].v, vs[k].d, vs[k].cnt}));
      @(negedge Clk);
      e = sb.pop_front();
      o = exp_t'({bus.InstAddress, bus.InstValid, bus.Done, bus.CycleCount});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap cyc %0d got pc=%h v=%b d=%b cnt=%0d want pc=%h v=%b d=%b cnt=%0d",
                 k, o.pc, o.v, o.d, o.cnt, e.pc, e.v, e.d, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t vs[$];
    exp_t e, o;
    clear_rom();
    rom[10'h101] = 9'h1FF;
    vs.push_back(mk(0, 1, 0, 0, 0, 1, 2, 'h020, 1, 0, 1, 4));
    vs.push_back(mk(0, 0, 0, 1, 2, 1, 2, 'h100, 0, 1, 0, 0));
    vs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 'h020, 1, 0, 1));
    vs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 'h100, 1, 0, 2));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h101, 1, 0, 3));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 'h101, 0, 1, 4));
    foreach (vs[k]) begin
      drive(vs[k]);
      sb.push_back(exp_t'({vs[k].pc, vs[k].v, vs[k].d, vs[k].cnt}));
      @(negedge Clk);
      e = sb.pop_front();
      o = exp_t'({bus.InstAddress, bus.InstValid, bus.Done, bus.CycleCount});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_lut cyc %0d got pc=%h v=%b d=%b cnt=%0d want pc=%h v=%b d=%b cnt=%0d",
                 k, o.pc, o.v, o.d, o.cnt, e.pc, e.v, e.d, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset_mid_run();
    vec_t vs[$];
    exp_t e, o;
    clear_rom();
    vs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 'h101, 0, 1, 4));
    for (int i = 0; i < 8; i++) vs.push_back(mk(i == 7, 0, 0, 0, 0, 0, 0, 0, i, 1, 0, i));
    vs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
    foreach (vs[k]) begin
      drive(vs[k]);
      sb.push_back(exp_t'({vs[k].pc, vs[k].v, vs[k].d, vs[k].cnt}));
      @(negedge Clk);
      e = sb.pop_front();
      o = exp_t'({bus.InstAddress, bus.InstValid, bus.Done, bus.CycleCount});
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got pc=%h v=%b d=%b cnt=%0d want pc=%h v=%b d=%b cnt=%0d",
                 k, o.pc, o.v, o.d, o.cnt, e.pc, e.v, e.d, e.cnt);
      end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_basic();
    test_branch();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program counter and fetch controller that drives the instruction ROM address. It starts a program on request and steps sequentially or branches through an 8-entry programmable branch-target LUT. It detects the halt word, stops fetching, and reports completion and a run-cycle count to the testbench/top level. The 3-bit branch field in an instruction is expanded to a full address here, not in the ROM.

Parameters:
A, 10, instruction address width (ROM depth 2**A)
W, 9, instruction width
CW, 16, cycle counter width

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  begin program from address 0 (sampled in IDLE or HALT only)
Stall  input  1  freeze PC this cycle (datapath hazard/multi-cycle op)
InstIn  input  W  instruction word returned by ROM for current InstAddress
BranchEn  input  1  take branch this cycle (from decode/ALU)
BranchIdx  input  3  LUT index selecting branch target
LutWe  input  1  LUT write enable
LutWaddr  input  3  LUT write index
LutWdata  input  A  LUT write data (absolute target address)
InstAddress  output  A  current PC, drives ROM address
InstValid  output  1  InstIn is a live instruction this cycle
Done  output  1  program halted
CycleCount  output  CW  cycles spent in RUN

Behaviour:
- One clock: Clk. Reset is synchronous and active-high.
- Reset value of every output:
  - InstAddress=0, InstValid=0, Done=0, CycleCount=0.
  - State=IDLE; all 8 LUT entries=0.
- InstAddress is the PC register directly. The ROM is combinational, so InstIn corresponds to InstAddress in the same cycle (zero-latency fetch).
- States: IDLE, RUN, HALT (registered).
- IDLE:
  - PC held at 0; InstValid=0; Done=0.
  - Start=1 -> RUN next cycle with PC=0 and CycleCount=0.
- RUN:
  - InstValid = !Stall (combinational from state and Stall).
  - CycleCount increments every RUN cycle, including stalled cycles; it saturates at all-ones and does not wrap.
  - Per-cycle PC update, first match wins:
    1. Stall=1 -> PC holds; halt and branch are not evaluated.
    2. InstIn == all-ones (halt word) -> state HALT, PC holds.
    3. BranchEn=1 -> PC = LUT[BranchIdx].
    4. Otherwise PC = PC+1, mod 2**A (2**A-1 wraps to 0, no error).
  - Start in RUN is ignored.
- HALT:
  - Done=1 (registered; first asserted the cycle after the halt word was seen).
  - InstValid=0; PC and CycleCount frozen.
  - Start=1 -> RUN next cycle with PC=0, CycleCount=0, Done=0.
- LUT:
  - 8 x A registers, writable in any state; the write takes effect at the clock edge.
  - A branch in the same cycle as a write to the same index uses the old value.
- Simultaneous Start and Reset: Reset wins.
- Reset mid-RUN: next cycle all registers take reset values; LUT contents are lost.
- A branch to a target holding the halt word halts one cycle later, as normal fetch.

Test Plan:
- Reset, then Start pulse with ROM {0:add,1:add,2:halt(1FF)} -> InstAddress 0,1,2; HALT entered; Done=1 the cycle after addr 2; CycleCount=3; InstValid low in HALT.
- LUT[5]=0x040 written; BranchEn=1, BranchIdx=5 at addr 3 -> next InstAddress=0x040, then 0x041.
- Stall held 2 cycles at addr 4 -> InstAddress stays 4, InstValid=0 for 2 cycles, CycleCount +2. Halt word present during stall does not halt until Stall drops.
- PC preloaded via branch to 0x3FF with non-halt word -> next InstAddress=0x000 (wrap).
- Same-cycle LUT write (idx2=0x100) and branch via idx2 (old 0x020) -> PC=0x020; a later branch via idx2 goes to 0x100.
- Reset asserted mid-RUN at addr 7 -> next cycle InstAddress=0, IDLE, Done=0, CycleCount=0, LUT cleared. Start in HALT restarts at 0 with Done cleared.
